// File: rtl/phy_rx_pkg.sv
// Shared state encoding and default link symbols for the phy_rx sync controller.
package phy_rx_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ALIGN   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RECOVER = 2'd3
  } sync_state_e;

  localparam logic [7:0] COM_DEFAULT = 8'hBC;
  localparam logic [7:0] IDL_DEFAULT = 8'h7C;

endpackage

// File: rtl/phy_rx_sync_timer.sv
// Byte-count timeout for SEARCH/RECOVER: expire pulses on the byte that would bring
// the count to TIMEOUT-1, and the count restarts from zero on that same byte.
module phy_rx_sync_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_f,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 2);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;

  assign expire = en && !clr && (to_cnt == TO_LAST);

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (clr || expire) begin
      to_cnt <= '0;
    end else if (en && (to_cnt != TO_MAX)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Receive link-sync controller: comma lock, COM/IDL stripping, error budget and re-align control.
// Optional PHY_RX_SYNC_STATS_EN adds bc_counter and lock_loss statistics outputs.
//
// state      | meaning
// SEARCH     | hunting for the first good comma; timeout requests re-align
// ALIGN      | counting consecutive good commas towards lock
// ACTIVE     | locked; data forwarded, COM/IDL stripped, errors budgeted
// RECOVER    | lock lost; waiting for a comma or timing out back to SEARCH
module phy_rx_sync_ctrl
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COM_BYTE    = COM_DEFAULT,
  parameter logic [7:0] IDL_BYTE    = IDL_DEFAULT,
  parameter int         LOCK_COMMAS = 4,
  parameter int         ERR_LIMIT   = 3,
  parameter int         TIMEOUT     = 64
) (
  input  logic       clk_f,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       sym_err,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       realign,
  output logic [1:0] state
`ifdef PHY_RX_SYNC_STATS_EN
  ,
  output logic [3:0] bc_counter,
  output logic [7:0] lock_loss
`endif
);

  localparam int COM_W = (LOCK_COMMAS > 1) ? $clog2(LOCK_COMMAS + 1) : 1;
  localparam int ERR_W = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT + 1) : 1;
  localparam logic [COM_W-1:0] COM_LOCK = COM_W'(LOCK_COMMAS);
  localparam logic [COM_W-1:0] COM_PRE  = COM_W'(LOCK_COMMAS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(ERR_LIMIT);
  localparam logic [ERR_W-1:0] ERR_PRE  = ERR_W'(ERR_LIMIT - 1);

  sync_state_e      state_q, state_nxt;
  logic [COM_W-1:0] com_cnt, com_nxt;
  logic [ERR_W-1:0] err_cnt, err_nxt;
  logic             good_com;
  logic             fwd;
  logic             realign_nxt;
  logic             to_en, to_clr, to_expire;

  assign good_com = byte_valid && !sym_err && (byte_in == COM_BYTE);
  assign state    = state_q;

  phy_rx_sync_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_f (clk_f),
    .reset (reset),
    .en    (to_en),
    .clr   (to_clr),
    .expire(to_expire)
  );

  always_comb begin
    state_nxt   = state_q;
    com_nxt     = com_cnt;
    err_nxt     = err_cnt;
    realign_nxt = 1'b0;
    fwd         = 1'b0;
    to_en       = 1'b0;
    to_clr      = 1'b0;
    if (byte_valid) begin
      case (state_q)
        ST_SEARCH, ST_RECOVER: begin
          if (good_com) begin
            com_nxt = COM_W'(1);
            to_clr  = 1'b1;
            if (LOCK_COMMAS == 1) begin
              state_nxt = ST_ACTIVE;
              err_nxt   = '0;
            end else begin
              state_nxt = ST_ALIGN;
            end
          end else begin
            to_en = 1'b1;
            if (to_expire) begin
              realign_nxt = 1'b1;
              state_nxt   = ST_SEARCH;
            end
          end
        end
        ST_ALIGN: begin
          to_clr = 1'b1;
          if (good_com) begin
            if (com_cnt >= COM_PRE) begin
              com_nxt   = COM_LOCK;
              state_nxt = ST_ACTIVE;
              err_nxt   = '0;
            end else begin
              com_nxt = com_cnt + 1'b1;
            end
          end else begin
            // any break in the comma run (IDL, data or errored byte) restarts the hunt
            com_nxt   = '0;
            state_nxt = ST_SEARCH;
          end
        end
        ST_ACTIVE: begin
          to_clr = 1'b1;
          if (sym_err) begin
            if (err_cnt >= ERR_PRE) begin
              err_nxt     = ERR_MAX;
              state_nxt   = ST_RECOVER;
              realign_nxt = 1'b1;
            end else begin
              err_nxt = err_cnt + 1'b1;
            end
          end else if (byte_in == COM_BYTE) begin
            err_nxt = '0;
          end else if (byte_in != IDL_BYTE) begin
            fwd = 1'b1;
          end
        end
        default: state_nxt = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SEARCH;
      com_cnt   <= '0;
      err_cnt   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      realign   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      com_cnt   <= com_nxt;
      err_cnt   <= err_nxt;
      valid_out <= fwd;
      active    <= (state_nxt == ST_ACTIVE);
      realign   <= realign_nxt;
      if (fwd) begin
        data_out <= byte_in;
      end
    end
  end

`ifdef PHY_RX_SYNC_STATS_EN
  logic leave_active;
  assign leave_active = (state_q == ST_ACTIVE) && (state_nxt != ST_ACTIVE);

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      bc_counter <= '0;
      lock_loss  <= '0;
    end else begin
      if (leave_active) begin
        bc_counter <= '0;
      end else if ((state_q == ST_ACTIVE) && good_com && (bc_counter != 4'hF)) begin
        bc_counter <= bc_counter + 1'b1;
      end
      if (leave_active && (state_nxt == ST_RECOVER) && (lock_loss != 8'hFF)) begin
        lock_loss <= lock_loss + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Directed and randomized checks of phy_rx_sync_ctrl against a byte-level behavioural model.
module tb_phy_rx_sync_ctrl;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;
  localparam int LOCK  = 4;
  localparam int ELIM  = 3;
  localparam int TOUT  = 64;
  localparam int MS_SEARCH = 0, MS_ALIGN = 1, MS_ACTIVE = 2, MS_RECOVER = 3;

  logic       clk_f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       sym_err = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, active, realign;
  logic [1:0] state;
`ifdef PHY_RX_SYNC_STATS_EN
  logic [3:0] bc_counter;
  logic [7:0] lock_loss;
`endif

  phy_rx_sync_ctrl dut (
    .clk_f     (clk_f),
    .reset     (reset),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .sym_err   (sym_err),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .realign   (realign),
    .state     (state)
`ifdef PHY_RX_SYNC_STATS_EN
    ,
    .bc_counter(bc_counter),
    .lock_loss (lock_loss)
`endif
  );

  always #5 clk_f = ~clk_f;

  int    tests = 0;
  int    fails = 0;
  int    realign_seen = 0;
  string phase = "init";

  // behavioural model: mode plus plain integer counts
  int         m_mode, m_commas, m_errs, m_idle_run, m_bc, m_ll;
  logic [7:0] m_data;
  bit         m_valid, m_realign;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MS_SEARCH; m_commas = 0; m_errs = 0; m_idle_run = 0;
    m_bc = 0; m_ll = 0; m_data = 8'h00; m_valid = 0; m_realign = 0;
  endtask

  task automatic model_step(input logic [7:0] b, input bit v, input bit e);
    bit good;
    m_valid = 0;
    m_realign = 0;
    if (!v) return;
    good = !e && (b == COM);
    if (m_mode == MS_SEARCH || m_mode == MS_RECOVER) begin
      if (good) begin
        m_commas = 1; m_idle_run = 0;
        m_mode = MS_ALIGN;
      end else begin
        m_idle_run++;
        if (m_idle_run == TOUT - 1) begin
          m_realign = 1; m_idle_run = 0; m_mode = MS_SEARCH;
        end
      end
    end else if (m_mode == MS_ALIGN) begin
      if (good) begin
        m_commas++;
        if (m_commas >= LOCK) begin m_mode = MS_ACTIVE; m_errs = 0; end
      end else begin
        m_mode = MS_SEARCH; m_commas = 0; m_idle_run = 0;
      end
    end else begin
      if (e) begin
        m_errs++;
        if (m_errs >= ELIM) begin
          m_mode = MS_RECOVER; m_realign = 1; m_bc = 0;
          if (m_ll < 255) m_ll++;
        end
      end else if (b == COM) begin
        m_errs = 0;
        if (m_bc < 15) m_bc++;
      end else if (b != IDL) begin
        m_data = b; m_valid = 1;
      end
    end
  endtask

  task automatic check_all();
    check("state", 32'(state), 32'(m_mode));
    check("active", 32'(active), 32'(m_mode == MS_ACTIVE));
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("realign", 32'(realign), 32'(m_realign));
    check("data_out", 32'(data_out), 32'(m_data));
`ifdef PHY_RX_SYNC_STATS_EN
    check("bc_counter", 32'(bc_counter), 32'(m_bc));
    check("lock_loss", 32'(lock_loss), 32'(m_ll));
`endif
  endtask

  task automatic send(input logic [7:0] b, input bit v = 1'b1, input bit e = 1'b0);
    @(negedge clk_f);
    byte_in = b; byte_valid = v; sym_err = e;
    @(posedge clk_f);
    model_step(b, v, e);
    #1;
    if (realign === 1'b1) realign_seen++;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk_f);
    reset = 1'b1; byte_valid = 1'b0; sym_err = 1'b0; byte_in = 8'h00;
    repeat (2) @(posedge clk_f);
    @(negedge clk_f);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int com_pct;
    logic [7:0] rb;
    bit rv, re;

    model_reset();
    do_reset();
    phase = "reset";
    check_all();
    check("state0", 32'(state), 32'd0);

    phase = "lock";
    repeat (3) send(COM);
    check("not_yet", 32'(active), 32'd0);
    send(COM);
    check("locked", 32'(active), 32'd1);
    send(8'h55);
    check("fwd_data", 32'(data_out), 32'h55);
    check("fwd_valid", 32'(valid_out), 32'd1);
    send(IDL);
    check("idl_drop", 32'(valid_out), 32'd0);

    phase = "errors";
    send(8'h00, 1, 1);
    send(8'h00, 1, 1);
    send(COM);
    send(8'h00, 1, 1);
    check("budget_refresh", 32'(state), 32'd2);
    send(8'h00, 1, 1);
    send(8'hA5, 1, 1);
    check("recover", 32'(state), 32'd3);
    check("recover_pulse", 32'(realign), 32'd1);
    check("recover_inactive", 32'(active), 32'd0);
    check("recover_nofwd", 32'(valid_out), 32'd0);
    send(8'h00, 0, 0);
    check("pulse_one_cycle", 32'(realign), 32'd0);

    phase = "broken_align";
    do_reset();
    send(COM); send(COM); send(8'h12);
    check("back_to_search", 32'(state), 32'd0);
    repeat (3) send(COM);
    check("still_aligning", 32'(active), 32'd0);
    send(COM);
    check("relocked", 32'(active), 32'd1);

    phase = "timeout";
    do_reset();
    realign_seen = 0;
    for (int i = 0; i < 62; i++) begin
      send(8'h00);
      if (i % 10 == 3) send(8'h00, 0, 0);
    end
    check("no_early_pulse", 32'(realign_seen), 32'd0);
    send(8'h00);
    check("expire_pulse", 32'(realign), 32'd1);
    repeat (62) send(8'h00);
    check("restart_count", 32'(realign_seen), 32'd1);
    send(8'h00);
    check("second_pulse", 32'(realign_seen), 32'd2);

    phase = "priority";
    do_reset();
    send(COM);
    send(COM, 1, 1);
    check("err_com_search", 32'(state), 32'd0);

    phase = "async_reset";
    repeat (4) send(COM);
    send(8'h33);
    @(negedge clk_f);
    #2 reset = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_realign", 32'(realign), 32'd0);
    model_reset();
    do_reset();
    check_all();

`ifdef PHY_RX_SYNC_STATS_EN
    phase = "stats";
    repeat (4) send(COM);
    repeat (20) send(COM);
    check("bc_sat", 32'(bc_counter), 32'd15);
    repeat (3) send(8'h00, 1, 1);
    check("lock_loss1", 32'(lock_loss), 32'd1);
    check("bc_cleared", 32'(bc_counter), 32'd0);
    repeat (4) send(COM);
    repeat (3) send(8'h00, 1, 1);
    check("lock_loss2", 32'(lock_loss), 32'd2);
`endif

    phase = "random";
    do_reset();
    com_pct = 40;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: com_pct = 3;
          1: com_pct = 40;
          default: com_pct = 85;
        endcase
      end
      rv = ($urandom_range(0, 99) < 85);
      re = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 99) < com_pct) rb = COM;
      else if ($urandom_range(0, 99) < 15) rb = IDL;
      else rb = 8'($urandom);
      send(rb, rv, re);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
